uart_transmitter: RTL and testbench

Serial UART transmitter: accepts one 8-bit byte per valid/ready handshake and shifts it out on `Tx`. Frame order is start bit, 8 data bits LSB first, optional even-parity bit, then stop bit(s). It sits upstream of `UART_Receiver` on the serial line and uses the same start/data/parity framing and the same baud parameterisation.

---
 rtl/uart_transmitter.sv | 134 +++++++++++++
 tb/tb_uart_transmitter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to include the even-parity bit in every frame.
module uart_transmitter #(
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       Tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    localparam logic [15:0] LastCnt = 16'(CYCLES_PER_BIT - 1);

    state_e      r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_stop_idx;
    logic [7:0]  r_shift;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif
    logic        r_tx;
    logic        r_busy;
    logic        r_tx_done;

    logic w_bit_end;
    logic w_last_stop;

    assign w_bit_end   = (r_baud_cnt == LastCnt);
    assign w_last_stop = (STOP_BITS == 2);
    assign ready       = (r_state == StIdle) && enable;
    assign Tx          = r_tx;
    assign busy        = r_busy;
    assign tx_done     = r_tx_done;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_state == StIdle) begin
                if (data_valid && ready) begin
                    r_shift    <= data_in;
`ifdef UART_TX_PARITY_EN
                    r_parity   <= ^data_in;
`endif
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_state    <= StStart;
                    r_tx       <= 1'b0;
                    r_busy     <= 1'b1;
                end
            end else if (!w_bit_end) begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end else begin
                r_baud_cnt <= '0;
                case (r_state)
                    StStart: begin
                        r_state <= StData;
                        r_tx    <= r_shift[0];
                    end
                    StData: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= StParity;
                            r_tx    <= r_parity;
`else
                            r_state    <= StStop;
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
`endif
                        end else begin
                            // Next bit is already at position 1 before this shift lands.
                            r_tx <= r_shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    StParity: begin
                        r_state    <= StStop;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
`endif
                    StStop: begin
                        if (r_stop_idx == w_last_stop) begin
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-level model checks two instances (1 and 2 stop bits)
// every cycle, plus directed frames compared against hand-written bit patterns.
module tb_uart_transmitter;

    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [11:0] ExpA5 = {2'b11, 1'b0, 8'hA5, 1'b0};
    localparam logic [11:0] Exp07 = {2'b11, 1'b1, 8'h07, 1'b0};
    localparam logic [11:0] Exp3C = {2'b11, 1'b0, 8'h3C, 1'b0};
    localparam logic [11:0] ExpC3 = {2'b11, 1'b0, 8'hC3, 1'b0};
    localparam logic [11:0] Exp5A = {2'b11, 1'b0, 8'h5A, 1'b0};
    localparam logic [11:0] Exp33 = {2'b11, 1'b0, 8'h33, 1'b0};
    localparam int Len1 = 110;
    localparam int Len2 = 120;
`else
    localparam int P = 0;
    localparam logic [11:0] ExpA5 = {3'b111, 8'hA5, 1'b0};
    localparam logic [11:0] Exp07 = {3'b111, 8'h07, 1'b0};
    localparam logic [11:0] Exp3C = {3'b111, 8'h3C, 1'b0};
    localparam logic [11:0] ExpC3 = {3'b111, 8'hC3, 1'b0};
    localparam logic [11:0] Exp5A = {3'b111, 8'h5A, 1'b0};
    localparam logic [11:0] Exp33 = {3'b111, 8'h33, 1'b0};
    localparam int Len1 = 100;
    localparam int Len2 = 110;
`endif

    logic       clk = 1'b0;
    logic       nRst;
    logic       enable;
    logic [7:0] data_in;
    logic       data_valid;
    logic [1:0] ready;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] tx_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.BAUD_RATE(10), .CLOCK_FREQ(100), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .nRst(nRst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
        .ready(ready[0]), .Tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );

    uart_transmitter #(.BAUD_RATE(10), .CLOCK_FREQ(100), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .nRst(nRst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
        .ready(ready[1]), .Tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line levels of a whole frame, one entry per bit period; unused tail stays high.
    function automatic logic [11:0] frame_bits(input logic [7:0] b);
        logic [11:0] v;
        v      = '1;
        v[0]   = 1'b0;
        v[8:1] = b;
        if (P == 1) v[9] = ^b;
        return v;
    endfunction

    // Model: a frame is active for len cycles after its acceptance edge.
    bit          m_act[2];
    bit          m_done[2];
    int          m_k[2];
    logic [11:0] m_bits[2];

    initial begin
        m_act = '{0, 0};
        m_done = '{0, 0};
        m_k = '{0, 0};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                if (!nRst) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    if (m_k[i] == (10 + P + i) * C) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_k[i]++;
                    end
                end else if (enable && data_valid) begin
                    m_act[i]  = 1'b1;
                    m_k[i]    = 1;
                    m_bits[i] = frame_bits(data_in);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                logic exp_tx;
                exp_tx = m_act[i] ? m_bits[i][(m_k[i] - 1) / C] : 1'b1;
                check(i == 0 ? "model_tx_s1" : "model_tx_s2", 32'(tx[i]), 32'(exp_tx));
                check(i == 0 ? "model_busy_s1" : "model_busy_s2", 32'(busy[i]), 32'(m_act[i]));
                check(i == 0 ? "model_done_s1" : "model_done_s2", 32'(tx_done[i]),
                      32'(m_done[i]));
                check(i == 0 ? "model_ready_s1" : "model_ready_s2", 32'(ready[i]),
                      32'(!m_act[i] && enable));
            end
        end
    end

    task automatic wait_idle(input bit both);
        int n;
        n = 0;
        while (!(ready[0] && (!both || !busy[1])) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        wait_idle(1'b0);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        if (!hold) data_valid = 1'b0;
        check("start_latency", 32'(tx[0]), 32'd0);
    endtask

    // Starts at a negedge inside frame cycle k0; samples each bit mid-period until tx_done.
    task automatic run_frame(input int k0, output logic [11:0] rec, output int nbusy,
                             output bit got_done);
        int k;
        k        = k0;
        rec      = '1;
        nbusy    = k0 - 1;
        got_done = 1'b0;
        while (k < 1000) begin
            if (tx_done[0]) begin
                got_done = 1'b1;
                break;
            end
            if (busy[0]) begin
                nbusy++;
                if ((k - 1) % C == C / 2 && (k - 1) / C < 12) rec[(k - 1) / C] = tx[0];
            end
            @(negedge clk);
            k++;
        end
        check("tx_done_seen", 32'(got_done), 32'd1);
    endtask

    logic [11:0] rec;
    int          nb;
    bit          gd;
    int          nb2;
    int          hi2;
    int          n2;

    initial begin
        nRst       = 1'b0;
        enable     = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(tx[0]), 32'd1);
            check("rst_busy", 32'(busy[0]), 32'd0);
            check("rst_done", 32'(tx_done[0]), 32'd0);
            check("rst_ready", 32'(ready[0]), 32'd1);
        end
        enable = 1'b0;
        #1;
        check("rst_ready_follows_enable", 32'(ready[0]), 32'd0);
        @(negedge clk);
        enable     = 1'b1;
        data_valid = 1'b0;
        nRst       = 1'b1;
        @(negedge clk);

        send(8'hA5, 1'b0);
        run_frame(1, rec, nb, gd);
        check("a5_bits", 32'(rec), 32'(ExpA5));
        check("a5_len", 32'(nb), 32'(Len1));

        send(8'h07, 1'b0);
        run_frame(1, rec, nb, gd);
        check("07_bits", 32'(rec), 32'(Exp07));
        check("07_len", 32'(nb), 32'(Len1));

        // Back-to-back with data_valid held; data_in changes while the first frame runs.
        send(8'h3C, 1'b1);
        data_in = 8'hC3;
        run_frame(2, rec, nb, gd);
        rec[0] = 1'b0;
        check("b2b_first_bits", 32'(rec), 32'(Exp3C));
        @(negedge clk);
        check("b2b_gap_tx", 32'(tx[0]), 32'd0);
        check("b2b_gap_busy", 32'(busy[0]), 32'd1);
        data_valid = 1'b0;
        run_frame(1, rec, nb, gd);
        check("b2b_second_bits", 32'(rec), 32'(ExpC3));

        send(8'h96, 1'b0);
        repeat (44) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx[0]), 32'd1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        nRst = 1'b1;
        @(negedge clk);
        send(8'h5A, 1'b0);
        run_frame(1, rec, nb, gd);
        check("after_rst_bits", 32'(rec), 32'(Exp5A));

        send(8'h81, 1'b0);
        repeat (29) @(negedge clk);
        enable = 1'b0;
        run_frame(30, rec, nb, gd);
        check("en_drop_len", 32'(nb), 32'(Len1));
        data_valid = 1'b1;
        data_in    = 8'h33;
        repeat (30) begin
            @(negedge clk);
            check("en_low_ready", 32'(ready[0]), 32'd0);
            check("en_low_busy", 32'(busy[0]), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        run_frame(1, rec, nb, gd);
        check("en_back_bits", 32'(rec), 32'(Exp33));

        // Two stop bits: all-zero byte leaves only the stop period high.
        wait_idle(1'b1);
        data_in    = 8'h00;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        nb2 = 0;
        hi2 = 0;
        n2  = 0;
        while (!tx_done[1] && n2 < 400) begin
            if (busy[1]) begin
                nb2++;
                if (tx[1]) hi2++;
            end
            @(negedge clk);
            n2++;
        end
        check("s2_done_seen", 32'(tx_done[1]), 32'd1);
        check("s2_stop_len", 32'(hi2), 32'd20);
        check("s2_frame_len", 32'(nb2), 32'(Len2));

        repeat (3000) begin
            @(negedge clk);
            data_in    = 8'($urandom);
            data_valid = ($urandom % 4) != 0;
            enable     = ($urandom % 16) != 0;
            nRst       = ($urandom % 512) != 0;
        end
        nRst       = 1'b1;
        enable     = 1'b1;
        data_valid = 1'b0;
        repeat (300) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
